// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: opcode/funct3 encodings, exception causes,
// access FSM states, and small decode helpers used by the stage and its lane aligner.
package mem_stage_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2,
        EXC_ILLEGAL  = 2'd3
    } exc_cause_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [4:0] opc);
        op_dec_t d;
        d           = '0;
        d.is_load   = (opc == OP_LOAD);
        d.is_store  = (opc == OP_STORE);
        d.is_branch = (opc == OP_BRANCH);
        d.is_jal    = (opc == OP_JAL);
        d.is_jalr   = (opc == OP_JALR);
        return d;
    endfunction

    // Byte-enable pattern for an access of 2**sz bytes starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
// Request is held until ACK; read data is only meaningful in the ACK cycle.
interface mem_stage_if;

    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [63:0] DMEM_ADDR;
    logic [63:0] DMEM_WDATA;
    logic [7:0]  DMEM_WSTRB;
    logic        DMEM_ACK;
    logic [63:0] DMEM_RDATA;

    modport master (
        output DMEM_REQ,
        output DMEM_WE,
        output DMEM_ADDR,
        output DMEM_WDATA,
        output DMEM_WSTRB,
        input  DMEM_ACK,
        input  DMEM_RDATA
    );

    modport slave (
        input  DMEM_REQ,
        input  DMEM_WE,
        input  DMEM_ADDR,
        input  DMEM_WDATA,
        input  DMEM_WSTRB,
        output DMEM_ACK,
        output DMEM_RDATA
    );

endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane aligner: store strobe/data shift, size legality and alignment checks, load extract+extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [2:0]  lane,
    input  logic [63:0] st_data,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic        misaligned,
    output logic        illegal,
    output logic [63:0] ld_data
);

    logic [63:0] shifted;
    logic        lane_off;

    always_comb begin
        illegal = (is_load && (funct3 == 3'b111)) || (is_store && funct3[2]);

        case (funct3[1:0])
            2'd0:    lane_off = 1'b0;
            2'd1:    lane_off = lane[0];
            2'd2:    lane_off = |lane[1:0];
            default: lane_off = |lane;
        endcase
        misaligned = (is_load || is_store) && !illegal && lane_off;

        wstrb = is_store ? (size_mask(funct3[1:0]) << lane) : 8'h00;
        wdata = st_data << {lane, 3'b000};
    end

    // Bring the addressed bytes down to bit 0, then extend from the access width.
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (funct3)
            F3_B:    ld_data = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    ld_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    ld_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   ld_data = {56'h0, shifted[7:0]};
            F3_HU:   ld_data = {48'h0, shifted[15:0]};
            F3_WU:   ld_data = {32'h0, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory stage: issues loads/stores on the DMEM bus, resolves redirects, registers MEM->WB.
// Latency: one cycle to WB for non-memory ops and zero-wait accesses; +N cycles while waiting for ACK.
// Backpressure: V_MEM_STALL holds upstream until ACK or timeout; the WB slot carries a bubble meanwhile.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            RESET,

    input  logic            MEM_V,
    input  logic [31:0]     MEM_IR,
    input  logic [XLEN-1:0] MEM_RES,
    input  logic [XLEN-1:0] MEM_Address,
    input  logic [XLEN-1:0] MEM_NPC,
    input  logic            MEM_PC_MUX,
    input  logic [XLEN-1:0] MEM_Target_Address,

    mem_stage_if.master     dmem,

    output logic            V_MEM_STALL,
    output logic            MEM_BR_Taken,
    output logic [XLEN-1:0] MEM_BR_Target,

    output logic            WB_V,
    output logic [XLEN-1:0] WB_RES,
    output logic [4:0]      WB_DR,
    output logic            WB_RegWrite,
    output logic [31:0]     WB_IR,
    output logic [XLEN-1:0] WB_NPC,
    output logic            WB_Exc,
    output logic [1:0]      WB_Exc_Cause
);

    localparam int             CW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(ACK_TIMEOUT - 1);

    op_dec_t     dec;
    logic [2:0]  funct3;
    logic        mem_op;
    logic        misaligned;
    logic        illegal;
    logic        access_ok;
    logic        timeout_hit;
    logic        exc;
    exc_cause_e  cause;
    logic [63:0] ld_data;
    logic [63:0] wb_res_nxt;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    state_e      state;
    logic [CW-1:0] cnt;

    assign dec    = decode_op(MEM_IR[6:2]);
    assign funct3 = MEM_IR[14:12];
    assign mem_op = MEM_V && (dec.is_load || dec.is_store);

    mem_align u_align (
        .is_load    (dec.is_load),
        .is_store   (dec.is_store),
        .funct3     (funct3),
        .lane       (MEM_Address[2:0]),
        .st_data    (MEM_RES),
        .rdata      (dmem.DMEM_RDATA),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .misaligned (misaligned),
        .illegal    (illegal),
        .ld_data    (ld_data)
    );

    // A bad access never reaches the bus; it retires immediately with an exception.
    assign access_ok   = mem_op && !misaligned && !illegal;
    assign timeout_hit = access_ok && (state == WAIT) && (cnt == TO_LAST) && !dmem.DMEM_ACK;

    assign dmem.DMEM_REQ   = access_ok && !timeout_hit;
    assign dmem.DMEM_WE    = dec.is_store;
    assign dmem.DMEM_ADDR  = {MEM_Address[63:3], 3'b000};
    assign dmem.DMEM_WDATA = wdata;
    assign dmem.DMEM_WSTRB = wstrb;

    assign V_MEM_STALL   = access_ok && !dmem.DMEM_ACK && !timeout_hit;
    assign MEM_BR_Taken  = MEM_V && ((dec.is_branch && MEM_PC_MUX) || dec.is_jal || dec.is_jalr);
    assign MEM_BR_Target = MEM_Target_Address;

    always_comb begin
        cause = EXC_NONE;
        if (mem_op) begin
            if (illegal)
                cause = EXC_ILLEGAL;
            else if (misaligned)
                cause = EXC_MISALIGN;
            else if (timeout_hit)
                cause = EXC_TIMEOUT;
        end
        exc = (cause != EXC_NONE);

        if (dec.is_load)
            wb_res_nxt = ld_data;
        else if (dec.is_jal || dec.is_jalr)
            wb_res_nxt = MEM_NPC;
        else
            wb_res_nxt = MEM_RES;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            WB_V         <= 1'b0;
            WB_RES       <= '0;
            WB_DR        <= '0;
            WB_RegWrite  <= 1'b0;
            WB_IR        <= '0;
            WB_NPC       <= '0;
            WB_Exc       <= 1'b0;
            WB_Exc_Cause <= EXC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (access_ok && !dmem.DMEM_ACK) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    // Leaving WAIT without a live access only happens if upstream dropped the op.
                    if (!access_ok || dmem.DMEM_ACK || timeout_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (V_MEM_STALL) begin
                WB_V         <= 1'b0;
                WB_RegWrite  <= 1'b0;
                WB_Exc       <= 1'b0;
                WB_Exc_Cause <= EXC_NONE;
            end else begin
                WB_V         <= MEM_V;
                WB_RES       <= wb_res_nxt;
                WB_DR        <= MEM_IR[11:7];
                WB_IR        <= MEM_IR;
                WB_NPC       <= MEM_NPC;
                WB_RegWrite  <= MEM_V && !exc && !dec.is_store && !dec.is_branch
                                && (MEM_IR[11:7] != 5'd0);
                WB_Exc       <= exc;
                WB_Exc_Cause <= cause;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops against a byte-level model.
module tb_mem_stage;

    localparam int TO = 4;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_ALU    = 5'b01100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_V;
    logic [31:0] MEM_IR;
    logic [63:0] MEM_RES;
    logic [63:0] MEM_Address;
    logic [63:0] MEM_NPC;
    logic        MEM_PC_MUX;
    logic [63:0] MEM_Target_Address;
    logic        V_MEM_STALL;
    logic        MEM_BR_Taken;
    logic [63:0] MEM_BR_Target;
    logic        WB_V;
    logic [63:0] WB_RES;
    logic [4:0]  WB_DR;
    logic        WB_RegWrite;
    logic [31:0] WB_IR;
    logic [63:0] WB_NPC;
    logic        WB_Exc;
    logic [1:0]  WB_Exc_Cause;

    int nchk  = 0;
    int nfail = 0;

    mem_stage_if dmem_bus ();

    mem_stage #(.XLEN(64), .ACK_TIMEOUT(TO)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .MEM_V              (MEM_V),
        .MEM_IR             (MEM_IR),
        .MEM_RES            (MEM_RES),
        .MEM_Address        (MEM_Address),
        .MEM_NPC            (MEM_NPC),
        .MEM_PC_MUX         (MEM_PC_MUX),
        .MEM_Target_Address (MEM_Target_Address),
        .dmem               (dmem_bus),
        .V_MEM_STALL        (V_MEM_STALL),
        .MEM_BR_Taken       (MEM_BR_Taken),
        .MEM_BR_Target      (MEM_BR_Target),
        .WB_V               (WB_V),
        .WB_RES             (WB_RES),
        .WB_DR              (WB_DR),
        .WB_RegWrite        (WB_RegWrite),
        .WB_IR              (WB_IR),
        .WB_NPC             (WB_NPC),
        .WB_Exc             (WB_Exc),
        .WB_Exc_Cause       (WB_Exc_Cause)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        exc;
        logic [1:0]  cause;
        logic        rw;
        logic [63:0] res;
        int          stall;
        logic        req;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic        taken;
        logic        st;
    } exp_t;

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [16:0] hi);
        return {hi, f3, rd, opc, 2'b11};
    endfunction

    // Reference: access size in bytes, byte-lane arithmetic, ACK arrival delay in cycles.
    function automatic exp_t model(input logic [31:0] ir, input logic [63:0] res,
                                   input logic [63:0] addr, input logic [63:0] npc,
                                   input logic pcmux, input logic [63:0] rdata, input int delay);
        exp_t        e;
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic        ld, st, br, jal, jalr, ill, mis, legal, tmo;
        int          nbytes, lane, m;
        logic [63:0] v, keep;
        opc    = ir[6:2];
        f3     = ir[14:12];
        ld     = (opc == OPC_LOAD);
        st     = (opc == OPC_STORE);
        br     = (opc == OPC_BRANCH);
        jal    = (opc == OPC_JAL);
        jalr   = (opc == OPC_JALR);
        nbytes = 1 << f3[1:0];
        lane   = int'(addr[2:0]);
        ill    = (ld && f3 == 3'd7) || (st && f3 >= 3'd4);
        mis    = (ld || st) && !ill && ((addr % 64'(nbytes)) != 0);
        legal  = (ld || st) && !ill && !mis;
        tmo    = legal && (delay > TO);
        e.st    = st;
        e.req   = legal;
        e.stall = legal ? (tmo ? TO : delay) : 0;
        e.cause = ill ? 2'd3 : mis ? 2'd1 : tmo ? 2'd2 : 2'd0;
        e.exc   = (e.cause != 2'd0);
        m       = ((1 << nbytes) - 1) << lane;
        e.wstrb = st ? m[7:0] : 8'h00;
        e.wdata = res << (8 * lane);
        v = rdata >> (8 * lane);
        if (nbytes < 8) begin
            keep = (64'd1 << (8 * nbytes)) - 64'd1;
            v    = v & keep;
            if (!f3[2] && v[8 * nbytes - 1]) v = v | ~keep;
        end
        e.res   = ld ? v : (jal || jalr) ? npc : res;
        e.rw    = !e.exc && !st && !br && (ir[11:7] != 5'd0);
        e.taken = (br && pcmux) || jal || jalr;
        return e;
    endfunction

    // Presents one op starting at posedge+1 and returns at posedge+1 after its completion edge.
    task automatic drive_op(input logic [31:0] ir, input logic [63:0] res, input logic [63:0] addr,
                            input logic [63:0] npc, input logic [63:0] tgt, input logic pcmux,
                            input logic [63:0] rdata, input int delay,
                            output int stalls, output logic req0, output logic req_last,
                            output logic [7:0] wstrb0, output logic [63:0] wdata0,
                            output logic taken0, output logic [63:0] tgt0, output logic hung);
        logic done;
        logic stl;
        MEM_V = 1'b1; MEM_IR = ir; MEM_RES = res; MEM_Address = addr; MEM_NPC = npc;
        MEM_Target_Address = tgt; MEM_PC_MUX = pcmux; dmem_bus.DMEM_RDATA = rdata;
        stalls = 0; done = 1'b0; req0 = 1'b0; req_last = 1'b0;
        wstrb0 = '0; wdata0 = '0; taken0 = 1'b0; tgt0 = '0;
        for (int k = 0; k < 40 && !done; k++) begin
            dmem_bus.DMEM_ACK = (k == delay);
            @(negedge CLK);
            if (k == 0) begin
                req0 = dmem_bus.DMEM_REQ; wstrb0 = dmem_bus.DMEM_WSTRB;
                wdata0 = dmem_bus.DMEM_WDATA; taken0 = MEM_BR_Taken; tgt0 = MEM_BR_Target;
            end
            req_last = dmem_bus.DMEM_REQ;
            stl = V_MEM_STALL;
            if (stl) stalls++;
            @(posedge CLK); #1;
            if (!stl) done = 1'b1;
        end
        dmem_bus.DMEM_ACK = 1'b0;
        hung = !done;
    endtask

    task automatic test_reset();
        RESET = 1'b1; MEM_V = 1'b0; MEM_IR = '0; MEM_RES = '0; MEM_Address = '0; MEM_NPC = '0;
        MEM_PC_MUX = 1'b0; MEM_Target_Address = '0;
        dmem_bus.DMEM_ACK = 1'b0; dmem_bus.DMEM_RDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        nchk++; if (WB_V !== 1'b0) begin nfail++; $display("FAIL reset_wb_v: got %b want 0", WB_V); end
        nchk++; if (WB_RES !== 64'h0) begin nfail++; $display("FAIL reset_wb_res: got %h want 0", WB_RES); end
        nchk++; if ({WB_DR, WB_IR, WB_NPC} !== '0) begin nfail++; $display("FAIL reset_wb_fields: got %h/%h/%h want 0", WB_DR, WB_IR, WB_NPC); end
        nchk++; if ({WB_RegWrite, WB_Exc, WB_Exc_Cause} !== 4'b0) begin nfail++; $display("FAIL reset_wb_flags: got %b%b%b want 0", WB_RegWrite, WB_Exc, WB_Exc_Cause); end
        nchk++; if (dmem_bus.DMEM_REQ !== 1'b0) begin nfail++; $display("FAIL reset_req: got %b want 0", dmem_bus.DMEM_REQ); end
        RESET = 1'b0;
    endtask

    task automatic test_load_sign();
        int st; logic r0, rl, tk, hg; logic [7:0] ws; logic [63:0] wd, tg;
        drive_op(mk_ir(OPC_LOAD, 3'b000, 5'd5, 17'h0), 64'h0, 64'h1003, 64'h1004, 64'h0, 1'b0,
                 64'h00000000_80000000, 0, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (hg !== 1'b0) begin nfail++; $display("FAIL lb_hung: got %b want 0", hg); end
        nchk++; if (st !== 0) begin nfail++; $display("FAIL lb_stall: got %0d want 0", st); end
        nchk++; if (r0 !== 1'b1) begin nfail++; $display("FAIL lb_req: got %b want 1", r0); end
        nchk++; if (WB_RES !== 64'hFFFFFFFF_FFFFFF80) begin nfail++; $display("FAIL lb_res: got %h want ffffffffffffff80", WB_RES); end
        nchk++; if (WB_RegWrite !== 1'b1) begin nfail++; $display("FAIL lb_regwrite: got %b want 1", WB_RegWrite); end
        nchk++; if (WB_V !== 1'b1 || WB_DR !== 5'd5) begin nfail++; $display("FAIL lb_v_dr: got %b/%0d want 1/5", WB_V, WB_DR); end
    endtask

    task automatic test_store_wait();
        int st; logic r0, rl, tk, hg; logic [7:0] ws; logic [63:0] wd, tg;
        drive_op(mk_ir(OPC_STORE, 3'b010, 5'd9, 17'h0), 64'hDEADBEEF, 64'h2004, 64'h2008, 64'h0, 1'b0,
                 64'h0, 3, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (st !== 3) begin nfail++; $display("FAIL sw_stall: got %0d want 3", st); end
        nchk++; if (ws !== 8'hF0) begin nfail++; $display("FAIL sw_wstrb: got %h want f0", ws); end
        nchk++; if (wd[63:32] !== 32'hDEADBEEF) begin nfail++; $display("FAIL sw_wdata: got %h want deadbeef", wd[63:32]); end
        nchk++; if (WB_RegWrite !== 1'b0) begin nfail++; $display("FAIL sw_regwrite: got %b want 0", WB_RegWrite); end
        nchk++; if (WB_V !== 1'b1 || WB_Exc !== 1'b0) begin nfail++; $display("FAIL sw_v_exc: got %b/%b want 1/0", WB_V, WB_Exc); end
    endtask

    task automatic test_bad_access();
        int st; logic r0, rl, tk, hg; logic [7:0] ws; logic [63:0] wd, tg;
        drive_op(mk_ir(OPC_LOAD, 3'b001, 5'd4, 17'h0), 64'h0, 64'h3001, 64'h0, 64'h0, 1'b0,
                 64'h0, 0, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (r0 !== 1'b0) begin nfail++; $display("FAIL lh_mis_req: got %b want 0", r0); end
        nchk++; if (st !== 0) begin nfail++; $display("FAIL lh_mis_stall: got %0d want 0", st); end
        nchk++; if (WB_Exc !== 1'b1 || WB_Exc_Cause !== 2'd1) begin nfail++; $display("FAIL lh_mis_exc: got %b/%0d want 1/1", WB_Exc, WB_Exc_Cause); end
        nchk++; if (WB_RegWrite !== 1'b0) begin nfail++; $display("FAIL lh_mis_regwrite: got %b want 0", WB_RegWrite); end
        drive_op(mk_ir(OPC_LOAD, 3'b111, 5'd4, 17'h0), 64'h0, 64'h3000, 64'h0, 64'h0, 1'b0,
                 64'h0, 0, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (r0 !== 1'b0 || WB_Exc_Cause !== 2'd3) begin nfail++; $display("FAIL ld_illegal: got req %b cause %0d want 0/3", r0, WB_Exc_Cause); end
        drive_op(mk_ir(OPC_STORE, 3'b100, 5'd4, 17'h0), 64'h0, 64'h3000, 64'h0, 64'h0, 1'b0,
                 64'h0, 0, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (r0 !== 1'b0 || WB_Exc_Cause !== 2'd3) begin nfail++; $display("FAIL st_illegal: got req %b cause %0d want 0/3", r0, WB_Exc_Cause); end
    endtask

    task automatic test_timeout();
        int st; logic r0, rl, tk, hg; logic [7:0] ws; logic [63:0] wd, tg;
        drive_op(mk_ir(OPC_LOAD, 3'b011, 5'd6, 17'h0), 64'h0, 64'h4008, 64'h0, 64'h0, 1'b0,
                 64'h1234, 100, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (st !== TO) begin nfail++; $display("FAIL tmo_stall: got %0d want %0d", st, TO); end
        nchk++; if (r0 !== 1'b1 || rl !== 1'b0) begin nfail++; $display("FAIL tmo_req: got first %b last %b want 1/0", r0, rl); end
        nchk++; if (WB_Exc !== 1'b1 || WB_Exc_Cause !== 2'd2) begin nfail++; $display("FAIL tmo_exc: got %b/%0d want 1/2", WB_Exc, WB_Exc_Cause); end
        nchk++; if (WB_RegWrite !== 1'b0) begin nfail++; $display("FAIL tmo_regwrite: got %b want 0", WB_RegWrite); end
        drive_op(mk_ir(OPC_ALU, 3'b000, 5'd3, 17'h0), 64'h55, 64'h0, 64'h10, 64'h0, 1'b0,
                 64'h0, 1, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (st !== 0 || WB_V !== 1'b1 || WB_RES !== 64'h55) begin nfail++; $display("FAIL tmo_next: got stall %0d v %b res %h want 0/1/55", st, WB_V, WB_RES); end
        drive_op(mk_ir(OPC_LOAD, 3'b010, 5'd6, 17'h0), 64'h0, 64'h4004, 64'h0, 64'h0, 1'b0,
                 64'h89ABCDEF_00000000, TO, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (st !== TO || WB_Exc !== 1'b0) begin nfail++; $display("FAIL ack_at_limit: got stall %0d exc %b want %0d/0", st, WB_Exc, TO); end
        nchk++; if (WB_RES !== 64'hFFFFFFFF_89ABCDEF) begin nfail++; $display("FAIL ack_at_limit_res: got %h want ffffffff89abcdef", WB_RES); end
    endtask

    task automatic test_branch();
        int st; logic r0, rl, tk, hg; logic [7:0] ws; logic [63:0] wd, tg;
        drive_op(mk_ir(OPC_JAL, 3'b000, 5'd1, 17'h0), 64'h999, 64'h0, 64'h104, 64'h200, 1'b0,
                 64'h0, 0, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (tk !== 1'b1 || tg !== 64'h200) begin nfail++; $display("FAIL jal_redirect: got %b/%h want 1/200", tk, tg); end
        nchk++; if (WB_RES !== 64'h104 || WB_RegWrite !== 1'b1) begin nfail++; $display("FAIL jal_wb: got %h/%b want 104/1", WB_RES, WB_RegWrite); end
        drive_op(mk_ir(OPC_BRANCH, 3'b001, 5'd2, 17'h0), 64'hABC, 64'h0, 64'h108, 64'h300, 1'b0,
                 64'h0, 0, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (tk !== 1'b0) begin nfail++; $display("FAIL bne_not_taken: got %b want 0", tk); end
        nchk++; if (WB_RegWrite !== 1'b0 || WB_V !== 1'b1) begin nfail++; $display("FAIL bne_wb: got rw %b v %b want 0/1", WB_RegWrite, WB_V); end
    endtask

    task automatic test_reset_in_wait();
        int st; logic r0, rl, tk, hg; logic [7:0] ws; logic [63:0] wd, tg;
        MEM_V = 1'b1; MEM_IR = mk_ir(OPC_LOAD, 3'b011, 5'd7, 17'h0); MEM_Address = 64'h5000;
        dmem_bus.DMEM_ACK = 1'b0;
        @(negedge CLK);
        nchk++; if (V_MEM_STALL !== 1'b1) begin nfail++; $display("FAIL rst_wait_stall: got %b want 1", V_MEM_STALL); end
        @(posedge CLK); @(posedge CLK); #3;
        RESET = 1'b1; #1;
        nchk++; if (WB_V !== 1'b0 || WB_RES !== 64'h0 || WB_IR !== 32'h0) begin nfail++; $display("FAIL rst_wait_clear: got %b/%h/%h want 0", WB_V, WB_RES, WB_IR); end
        MEM_V = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0; dmem_bus.DMEM_ACK = 1'b1;
        @(negedge CLK);
        nchk++; if (dmem_bus.DMEM_REQ !== 1'b0 || V_MEM_STALL !== 1'b0) begin nfail++; $display("FAIL late_ack_req: got %b/%b want 0/0", dmem_bus.DMEM_REQ, V_MEM_STALL); end
        @(posedge CLK); #1;
        dmem_bus.DMEM_ACK = 1'b0;
        nchk++; if (WB_V !== 1'b0 || WB_RegWrite !== 1'b0) begin nfail++; $display("FAIL late_ack_wb: got %b/%b want 0/0", WB_V, WB_RegWrite); end
        drive_op(mk_ir(OPC_LOAD, 3'b011, 5'd7, 17'h0), 64'h0, 64'h5000, 64'h0, 64'h0, 1'b0,
                 64'h0123_4567_89AB_CDEF, 0, st, r0, rl, ws, wd, tk, tg, hg);
        nchk++; if (st !== 0 || WB_V !== 1'b1 || WB_RES !== 64'h0123_4567_89AB_CDEF) begin nfail++; $display("FAIL post_rst_ld: got stall %0d v %b res %h", st, WB_V, WB_RES); end
    endtask

    task automatic test_random();
        logic [4:0] opcs [6];
        opcs[0] = OPC_LOAD; opcs[1] = OPC_STORE; opcs[2] = OPC_BRANCH;
        opcs[3] = OPC_JAL;  opcs[4] = OPC_JALR;  opcs[5] = OPC_ALU;
        for (int i = 0; i < 80; i++) begin
            int st; logic r0, rl, tk, hg; logic [7:0] ws; logic [63:0] wd, tg;
            logic [31:0] ir; logic [63:0] res, addr, npc, tgt, rdata; logic pcm; int dly;
            logic [2:0] f3; exp_t e;
            f3    = 3'($urandom_range(0, 7));
            ir    = mk_ir(opcs[$urandom_range(0, 5)], f3, 5'($urandom_range(0, 31)), 17'($urandom));
            res   = {$urandom, $urandom};
            addr  = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
            npc   = {$urandom, $urandom};
            tgt   = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            pcm   = 1'($urandom_range(0, 1));
            dly   = $urandom_range(0, 6);
            e = model(ir, res, addr, npc, pcm, rdata, dly);
            drive_op(ir, res, addr, npc, tgt, pcm, rdata, dly, st, r0, rl, ws, wd, tk, tg, hg);
            nchk++; if (hg !== 1'b0 || st !== e.stall) begin nfail++; $display("FAIL rnd%0d_stall: got %0d hung %b want %0d", i, st, hg, e.stall); end
            nchk++; if (r0 !== e.req || ws !== e.wstrb) begin nfail++; $display("FAIL rnd%0d_bus: got req %b strb %h want %b %h", i, r0, ws, e.req, e.wstrb); end
            if (e.st) begin
                nchk++; if (wd !== e.wdata) begin nfail++; $display("FAIL rnd%0d_wdata: got %h want %h", i, wd, e.wdata); end
            end
            nchk++; if (tk !== e.taken || tg !== tgt) begin nfail++; $display("FAIL rnd%0d_redirect: got %b %h want %b %h", i, tk, tg, e.taken, tgt); end
            nchk++; if (WB_V !== 1'b1 || WB_IR !== ir || WB_NPC !== npc || WB_DR !== ir[11:7]) begin nfail++; $display("FAIL rnd%0d_wb_pass: got v %b ir %h npc %h dr %0d", i, WB_V, WB_IR, WB_NPC, WB_DR); end
            nchk++; if (WB_Exc !== e.exc || WB_Exc_Cause !== e.cause || WB_RegWrite !== e.rw) begin nfail++; $display("FAIL rnd%0d_wb_flags: got exc %b cause %0d rw %b want %b %0d %b", i, WB_Exc, WB_Exc_Cause, WB_RegWrite, e.exc, e.cause, e.rw); end
            if (!e.exc) begin
                nchk++; if (WB_RES !== e.res) begin nfail++; $display("FAIL rnd%0d_wb_res: got %h want %h", i, WB_RES, e.res); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_sign();
        test_store_wait();
        test_bad_access();
        test_timeout();
        test_branch();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage. It consumes the EXE→MEM register interface and performs RV64 loads and stores through a request/acknowledge data-memory port.
- It resolves branch/jump redirects toward fetch and registers results into the MEM→WB interface.
- It stalls upstream stages while a data access is outstanding. It flags misaligned accesses, illegal access sizes and bus timeouts.

Parameters:
- XLEN, 64, datapath width (fixed 64; byte lanes assume 8).
- ACK_TIMEOUT, 255, maximum cycles spent in WAIT before a bus-error completion (≥1).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- MEM_V  in  1  instruction in MEM is valid.
- MEM_IR  in  32  instruction word.
- MEM_RES  in  64  ALU result; carries rs2 store data for stores.
- MEM_Address  in  64  effective load/store address.
- MEM_NPC  in  64  PC+4 of the instruction.
- MEM_PC_MUX  in  1  branch condition result.
- MEM_Target_Address  in  64  branch/jump target.
- DMEM_ACK  in  1  memory completes the request this cycle.
- DMEM_RDATA  in  64  doubleword containing the address; valid with ACK.
- DMEM_REQ  out  1  access request.
- DMEM_WE  out  1  1 = store.
- DMEM_ADDR  out  64  {MEM_Address[63:3],3'b000}.
- DMEM_WDATA  out  64  lane-shifted store data.
- DMEM_WSTRB  out  8  byte enables.
- V_MEM_STALL  out  1  hold upstream stages and MEM inputs.
- MEM_BR_Taken  out  1  redirect fetch.
- MEM_BR_Target  out  64  redirect PC.
- WB_V  out  1  registered valid.
- WB_RES  out  64  writeback value.
- WB_DR  out  5  destination register.
- WB_RegWrite  out  1  write rd.
- WB_IR  out  32  instruction.
- WB_NPC  out  64  NPC.
- WB_Exc  out  1  exception.
- WB_Exc_Cause  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal size.

Behaviour:
- Decode on MEM_IR[6:2]:
  - 00000 load.
  - 01000 store.
  - 11000 branch.
  - 11001 JALR.
  - 11011 JAL.
  - funct3 = MEM_IR[14:12].
- Load sizes: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Load funct3 111 is illegal size.
- Store sizes: 000 SB, 001 SH, 010 SW, 011 SD. Store funct3 1xx is illegal size.
- Misaligned: address not a multiple of the access size. Misaligned and illegal accesses issue no request and complete in one cycle, with WB_Exc=1 and WB_RegWrite=0.
- FSM state IDLE:
  - Valid legal memory op → DMEM_REQ=1, combinational from inputs.
  - If DMEM_ACK is set in the same cycle, the op completes (zero wait) and the FSM stays in IDLE.
  - Otherwise the FSM goes to WAIT and clears the timeout counter.
- FSM state WAIT:
  - DMEM_REQ stays 1. Inputs are stable because the stall holds them; counter increments.
  - On DMEM_ACK: complete, go to IDLE.
  - On counter == ACK_TIMEOUT-1 without ACK: complete with cause 2, DMEM_REQ drops, go to IDLE.
  - If ACK and timeout occur together, ACK wins.
- V_MEM_STALL = MEM_V & legal memory op & ~DMEM_ACK & ~timeout-completion. It deasserts in the completion cycle.
- Lane = MEM_Address[2:0].
  - Store: WDATA = rs2 << (8·lane). WSTRB = size mask << lane (0x01/0x03/0x0F/0xFF).
  - Load: data = RDATA >> (8·lane), then sign- or zero-extend per funct3.
- WB register update (every non-stalled cycle):
  - WB_V = MEM_V.
  - WB_IR, WB_NPC, WB_DR = MEM_IR[11:7] pass through.
  - WB_RES: load data for loads; MEM_NPC for JAL/JALR; MEM_RES otherwise.
  - WB_RegWrite = MEM_V & ~exception & not store/branch & DR≠0.
  - While stalled, WB_V is registered 0 (bubble).
- Redirect (combinational):
  - MEM_BR_Taken = MEM_V & ((branch & MEM_PC_MUX) | JAL | JALR).
  - MEM_BR_Target = MEM_Target_Address.
- Reset (asynchronous, any cycle including mid-WAIT):
  - State → IDLE, counter → 0.
  - WB_V, WB_RegWrite, WB_Exc → 0. WB_Exc_Cause → 0. WB_RES, WB_IR, WB_NPC → 0. WB_DR → 0.
- A DMEM_ACK arriving while IDLE with no request is ignored.

Decomposition:
- Shared package holds:
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR;
  - funct3 size constants;
  - exception cause enum;
  - FSM state enum {IDLE, WAIT}.
- One sub-module, mem_align: purely combinational. It produces the WSTRB/WDATA lane shift, the misaligned/illegal detect and load extraction with extension.

Test Plan:
- LB at address 0x1003, RDATA=0x00000000_80000000 with immediate ACK → WB_RES=0xFFFFFFFF_FFFFFF80, WB_RegWrite=1, no stall.
- SW at 0x2004, rs2=0xDEADBEEF, ACK after 3 cycles → WSTRB=0xF0, WDATA[63:32]=0xDEADBEEF, V_MEM_STALL high 3 cycles, WB_RegWrite=0.
- LH at 0x3001 → no DMEM_REQ, WB_Exc=1, cause 1, no stall.
- LD with ACK_TIMEOUT=4, ACK never arrives → stall 4 cycles, then WB_Exc=1, cause 2, REQ drops, next instruction proceeds.
- JAL with MEM_NPC=0x104, target 0x200 → MEM_BR_Taken=1, MEM_BR_Target=0x200, WB_RES=0x104. BNE with MEM_PC_MUX=0 → MEM_BR_Taken=0.
- RESET asserted in WAIT, then ACK after release → state IDLE, WB_V=0, the late ACK produces no writeback.
